vmem_arbiter: RTL and testbench
===============================

// Module: vmem_arbiter
// PURPOSE
//   Shares one single-port video RAM between the VGA scan-out reader and a pixel writer.
//   Scan-out reads always win the RAM. Writes are queued in a small FIFO and drained on idle cycles.
//   A built-in clear engine fills the whole frame with a single colour.
//   Sits between vga_ctrl (read side), the keyboard/draw logic (write side) and the frame RAM.
// PARAMETERS
//   AW          19      RAM address width ({h_addr[9:0], v_addr[8:0]})
//   DW          24      pixel width (RGB888)
//   FIFO_DEPTH  4       write FIFO entries; power of 2, >= 2
//   CLR_LAST    524287  last address written by a clear (first address is 0)
// PORTS
//   clk          in   1                     system clock (pixel clock)
//   resetn       in   1                     synchronous reset, active-low
//   disp_req     in   1                     scan-out read request this cycle
//   disp_addr    in   AW                    scan-out read address
//   disp_rvalid  out  1                     disp_rdata valid (read issued the previous cycle)
//   disp_rdata   out  DW                    read pixel
//   wr_valid     in   1                     write request
//   wr_ready     out  1                     FIFO accepts the write this cycle
//   wr_addr      in   AW                    write address
//   wr_data      in   DW                    write pixel
//   clr_start    in   1                     start-clear pulse
//   clr_color    in   DW                    fill colour, sampled with clr_start
//   clr_busy     out  1                     clear in progress
//   fifo_level   out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
//   mem_en       out  1                     RAM access enable
//   mem_we       out  1                     RAM write enable
//   mem_addr     out  AW                    RAM address
//   mem_wdata    out  DW                    RAM write data
//   mem_rdata    in   DW                    RAM read data; synchronous, 1-cycle latency
// BEHAVIOUR
//   - Reset (resetn=0 at a clk edge) takes effect on that edge:
//     FSM=IDLE, FIFO empty, fifo_level=0, disp_rvalid=0, clr_busy=0, clear address=0.
//   - While resetn=0: mem_en=0, mem_we=0 and wr_ready=0, overriding all requests.
//   - RAM grant, combinational, fixed priority:
//     1. disp_req: read at disp_addr.
//     2. FIFO non-empty: write the FIFO head.
//     3. FSM=CLEAR: write clr_color at the clear address.
//     4. Otherwise: mem_en=0.
//   - mem_we=1 only on grants 2 and 3. mem_wdata/mem_addr are don't-care when mem_en=0.
//   - Read path: disp_rvalid is disp_req registered by one cycle. disp_rdata=mem_rdata (passthrough).
//     Read latency is always exactly 1 cycle; a read is never stalled.
//   - FIFO:
//     - wr_ready = !full && FSM==IDLE && resetn. Push on wr_valid&&wr_ready.
//     - Pop on grant 2. A push and a pop in the same cycle leave the level unchanged.
//     - No write bypass: a write entering an empty FIFO reaches RAM no earlier than the next cycle.
//     - Writes retire in acceptance order. Only the last write to a given address is visible.
//   - Clear FSM:
//     - IDLE->CLEAR on clr_start in IDLE: latch clr_color, clear address=0, clr_busy=1 from the next cycle.
//     - In CLEAR: each grant-3 cycle writes the latched colour, then clear address+=1.
//     - On the grant that writes CLR_LAST: ->IDLE, clr_busy=0 next cycle.
//     - clr_start in CLEAR is ignored. The clear address never wraps.
//     - FIFO entries accepted before clr_start drain first (priority 2 > 3).
//       No new writes are accepted during CLEAR.
//   - Scan-out starvation of writes/clear is permitted. The block has no timeout or error output.
// TESTING
//   1. resetn=0 for 3 cycles with disp_req=1, wr_valid=1 -> mem_en=0, wr_ready=0, disp_rvalid=0;
//      after release fifo_level=0, wr_ready=1.
//   2. disp_req=1, disp_addr=0x00123, RAM model returns 0xABCDEF ->
//      mem_en=1, mem_we=0 same cycle; disp_rvalid=1, disp_rdata=0xABCDEF next cycle.
//   3. disp_req held 1; push writes A0..A3 (0x10..0x13) -> fifo_level=4, wr_ready=0, mem_we stays 0;
//      drop disp_req -> 4 consecutive writes in order A0..A3, level counts 4->0.
//   4. CLR_LAST=7, clr_start with colour 0x102030, disp_req=1 on 2 scattered cycles ->
//      8 writes to addresses 0..7, all 0x102030, over 10 cycles; clr_busy falls after address 7.
//   5. Push 2 writes, then clr_start -> both FIFO writes hit RAM before clear address 0;
//      wr_valid during CLEAR sees wr_ready=0.
//   6. resetn=0 for one cycle while clear address=3 ->
//      clr_busy=0, no further mem_we, later clr_start restarts the clear at address 0.

Source files
------------

// File: rtl/vmem_arbiter.sv
// rtl/vmem_arbiter.sv - video RAM arbiter: scan-out reads, queued pixel writes, frame clear engine
module vmem_arbiter #(
  parameter int AW         = 19,
  parameter int DW         = 24,
  parameter int FIFO_DEPTH = 4,
  parameter int CLR_LAST   = 524287
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          disp_req,
  input  logic [AW-1:0]                 disp_addr,
  output logic                          disp_rvalid,
  output logic [DW-1:0]                 disp_rdata,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [AW-1:0]                 wr_addr,
  input  logic [DW-1:0]                 wr_data,
  input  logic                          clr_start,
  input  logic [DW-1:0]                 clr_color,
  output logic                          clr_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [AW-1:0]                 mem_addr,
  output logic [DW-1:0]                 mem_wdata,
  input  logic [DW-1:0]                 mem_rdata
);

  localparam int LW = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0] CLR_LAST_A = AW'(CLR_LAST);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        state;
  logic [AW-1:0] fifo_addr [FIFO_DEPTH];
  logic [DW-1:0] fifo_data [FIFO_DEPTH];
  logic [LW-1:0] wptr, rptr;
  logic [LW:0]   count;
  logic [AW-1:0] clr_addr;
  logic [DW-1:0] clr_color_q;
  logic          empty, full, push, pop, clr_wr;

  assign empty    = (count == '0);
  assign full     = (count == (LW+1)'(FIFO_DEPTH));
  assign wr_ready = resetn && !full && (state == IDLE);
  assign push     = wr_valid && wr_ready;
  assign pop      = resetn && !disp_req && !empty;
  assign clr_wr   = resetn && !disp_req && empty && (state == CLEAR);

  assign disp_rdata = mem_rdata;
  assign fifo_level = count;

  // Fixed priority: scan-out read, then FIFO head, then clear engine.
  always_comb begin
    mem_en    = resetn && (disp_req || !empty || (state == CLEAR));
    mem_we    = pop || clr_wr;
    mem_addr  = clr_addr;
    mem_wdata = clr_color_q;
    if (disp_req) begin
      mem_addr = disp_addr;
    end else if (!empty) begin
      mem_addr  = fifo_addr[rptr];
      mem_wdata = fifo_data[rptr];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wptr] <= wr_addr;
      fifo_data[wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + LW'(1);
      if (pop)  rptr <= rptr + LW'(1);
      case ({push, pop})
        2'b10:   count <= count + (LW+1)'(1);
        2'b01:   count <= count - (LW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      disp_rvalid <= 1'b0;
    end else begin
      disp_rvalid <= disp_req;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      clr_busy    <= 1'b0;
      clr_addr    <= '0;
      clr_color_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_start) begin
            state       <= CLEAR;
            clr_busy    <= 1'b1;
            clr_addr    <= '0;
            clr_color_q <= clr_color;
          end
        end
        CLEAR: begin
          if (clr_wr) begin
            if (clr_addr == CLR_LAST_A) begin
              state    <= IDLE;
              clr_busy <= 1'b0;
            end else begin
              clr_addr <= clr_addr + AW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vmem_arbiter.sv
// tb/tb_vmem_arbiter.sv - self-checking bench for vmem_arbiter
module tb_vmem_arbiter;
  localparam int AW = 19;
  localparam int DW = 24;
  localparam int LAST = 7;

  logic          clk = 1'b0;
  logic          resetn;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_rvalid;
  logic [DW-1:0] disp_rdata;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          clr_start;
  logic [DW-1:0] clr_color;
  logic          clr_busy;
  logic [2:0]    fifo_level;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int vectors = 0;
  int errs = 0;

  vmem_arbiter #(.AW(AW), .DW(DW), .FIFO_DEPTH(4), .CLR_LAST(LAST)) dut (
    .clk(clk), .resetn(resetn),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy), .fifo_level(fifo_level),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM with 1-cycle read latency
  logic [DW-1:0] ram [int unsigned];
  function automatic logic [DW-1:0] ram_rd(input int unsigned a);
    return ram.exists(a) ? ram[a] : '0;
  endfunction
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[int'(mem_addr)] = mem_wdata;
      else        mem_rdata <= ram_rd(int'(mem_addr));
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  typedef struct {
    logic          dreq;
    logic [AW-1:0] daddr;
    logic          wv;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          e_en;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic          e_ready;
    logic [2:0]    e_level;
  } vec_t;

  vec_t tbl[10];

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           q[$];
  logic [DW-1:0] shadow [int unsigned];
  int            nw;
  int            budget;
  bit            clearing, clearing_pre, prev_req, exp_ready;
  int            caddr;
  logic [DW-1:0] ccol, prev_val, col;

  function automatic logic [DW-1:0] sh_rd(input int unsigned a);
    return shadow.exists(a) ? shadow[a] : '0;
  endfunction

  initial begin
    resetn = 1'b0; disp_req = 1'b1; disp_addr = '0; wr_valid = 1'b1;
    wr_addr = '0; wr_data = '0; clr_start = 1'b0; clr_color = '0;

    // Reset overrides all requests
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_rvalid", disp_rvalid, 0);
    end
    tick();
    resetn = 1'b1; disp_req = 1'b0; wr_valid = 1'b0;
    #1;
    chk("post_rst_level", fifo_level, 0);
    chk("post_rst_wr_ready", wr_ready, 1);
    chk("post_rst_busy", clr_busy, 0);

    // Single scan-out read
    ram[32'h123] = 24'hABCDEF;
    tick();
    disp_req = 1'b1; disp_addr = 19'h00123;
    #1;
    chk("rd_en", mem_en, 1);
    chk("rd_we", mem_we, 0);
    chk("rd_addr", mem_addr, 32'h123);
    tick();
    disp_req = 1'b0;
    #1;
    chk("rd_rvalid", disp_rvalid, 1);
    chk("rd_rdata", disp_rdata, 32'hABCDEF);

    // Table: fill FIFO under continuous reads, then drain
    tbl[0] = '{1, 5, 1, 'h10, 'hA0,  1, 0, 5,    0,    1, 0};
    tbl[1] = '{1, 5, 1, 'h11, 'hA1,  1, 0, 5,    0,    1, 1};
    tbl[2] = '{1, 5, 1, 'h12, 'hA2,  1, 0, 5,    0,    1, 2};
    tbl[3] = '{1, 5, 1, 'h13, 'hA3,  1, 0, 5,    0,    1, 3};
    tbl[4] = '{1, 5, 1, 'h99, 'h99,  1, 0, 5,    0,    0, 4};
    tbl[5] = '{0, 0, 0, 0,    0,     1, 1, 'h10, 'hA0, 0, 4};
    tbl[6] = '{0, 0, 0, 0,    0,     1, 1, 'h11, 'hA1, 1, 3};
    tbl[7] = '{0, 0, 0, 0,    0,     1, 1, 'h12, 'hA2, 1, 2};
    tbl[8] = '{0, 0, 0, 0,    0,     1, 1, 'h13, 'hA3, 1, 1};
    tbl[9] = '{0, 0, 0, 0,    0,     0, 0, 0,    0,    1, 0};
    for (int i = 0; i < 10; i++) begin
      tick();
      disp_req = tbl[i].dreq; disp_addr = tbl[i].daddr;
      wr_valid = tbl[i].wv; wr_addr = tbl[i].waddr; wr_data = tbl[i].wdata;
      #1;
      chk($sformatf("tbl%0d_en", i), mem_en, tbl[i].e_en);
      chk($sformatf("tbl%0d_we", i), mem_we, tbl[i].e_we);
      if (tbl[i].e_en) chk($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].e_addr);
      if (tbl[i].e_we) chk($sformatf("tbl%0d_wdata", i), mem_wdata, tbl[i].e_wdata);
      chk($sformatf("tbl%0d_ready", i), wr_ready, tbl[i].e_ready);
      chk($sformatf("tbl%0d_level", i), fifo_level, tbl[i].e_level);
    end

    // Clear with two interleaved scan-out reads
    tick();
    clr_start = 1'b1; clr_color = 24'h102030;
    #1;
    chk("clr_idle_busy", clr_busy, 0);
    tick();
    clr_start = 1'b0;
    nw = 0;
    for (int c = 0; c < 10; c++) begin
      disp_req = (c == 2 || c == 6);
      #1;
      if (c == 0) chk("clr_busy_on", clr_busy, 1);
      if (disp_req) chk("clr_read_we", mem_we, 0);
      if (mem_we) begin
        chk("clr_addr", mem_addr, nw);
        chk("clr_data", mem_wdata, 32'h102030);
        nw++;
      end
      tick();
    end
    disp_req = 1'b0;
    #1;
    chk("clr_writes", nw, 8);
    chk("clr_busy_off", clr_busy, 0);
    chk("clr_done_en", mem_en, 0);

    // FIFO entries accepted before clr_start drain first
    tick();
    disp_req = 1'b1; wr_valid = 1'b1; wr_addr = 'h20; wr_data = 'h111;
    tick();
    wr_addr = 'h21; wr_data = 'h222;
    tick();
    wr_valid = 1'b0; clr_start = 1'b1; clr_color = 24'h55;
    tick();
    clr_start = 1'b0; disp_req = 1'b0; wr_valid = 1'b1; wr_addr = 'h30; wr_data = 'h333;
    #1;
    chk("drain0_addr", mem_addr, 'h20);
    chk("drain0_we", mem_we, 1);
    chk("drain_ready", wr_ready, 0);
    tick();
    #1;
    chk("drain1_addr", mem_addr, 'h21);
    chk("drain1_data", mem_wdata, 'h222);
    chk("drain_ready2", wr_ready, 0);
    tick();
    wr_valid = 1'b0;
    #1;
    chk("drain_clr0_addr", mem_addr, 0);
    chk("drain_clr0_data", mem_wdata, 'h55);
    budget = 0;
    while (clr_busy && budget < 20) begin tick(); budget++; end
    chk("drain_clr_timeout", clr_busy, 0);

    // Reset in the middle of a clear
    tick();
    clr_start = 1'b1; clr_color = 24'h77;
    tick();
    clr_start = 1'b0;
    tick(); tick(); tick();
    #1;
    chk("mid_clr_addr3", mem_addr, 3);
    resetn = 1'b0;
    #1;
    chk("mid_rst_we", mem_we, 0);
    tick();
    resetn = 1'b1;
    #1;
    chk("mid_rst_busy", clr_busy, 0);
    for (int i = 0; i < 3; i++) begin
      chk("mid_rst_no_we", mem_we, 0);
      tick();
    end
    clr_start = 1'b1; clr_color = 24'h88;
    tick();
    clr_start = 1'b0;
    #1;
    chk("restart_addr", mem_addr, 0);
    chk("restart_data", mem_wdata, 'h88);
    chk("restart_we", mem_we, 1);
    budget = 0;
    while (clr_busy && budget < 20) begin tick(); budget++; end
    chk("restart_timeout", clr_busy, 0);

    // Randomized traffic against a queue-based reference model
    ram.delete();
    q.delete();
    clearing = 0; caddr = 0; ccol = '0; prev_req = 0; prev_val = '0;
    tick();
    for (int cyc = 0; cyc < 600; cyc++) begin
      disp_req  = ($urandom_range(0, 9) < 4);
      disp_addr = AW'($urandom_range(0, 15));
      wr_valid  = $urandom_range(0, 1);
      wr_addr   = AW'($urandom_range(0, 15));
      wr_data   = DW'($urandom);
      clr_start = ($urandom_range(0, 39) == 0);
      clr_color = DW'($urandom);
      #1;
      clearing_pre = clearing;
      exp_ready = (q.size() < 4) && !clearing;
      chk("rnd_ready", wr_ready, exp_ready);
      chk("rnd_level", fifo_level, q.size());
      chk("rnd_busy", clr_busy, clearing);
      chk("rnd_rvalid", disp_rvalid, prev_req);
      if (prev_req) chk("rnd_rdata", disp_rdata, prev_val);
      if (disp_req) begin
        chk("rnd_rd_en", mem_en, 1);
        chk("rnd_rd_we", mem_we, 0);
        chk("rnd_rd_addr", mem_addr, disp_addr);
        prev_val = sh_rd(int'(disp_addr));
      end else if (q.size() > 0) begin
        chk("rnd_fw_we", mem_we, 1);
        chk("rnd_fw_addr", mem_addr, q[0].a);
        chk("rnd_fw_data", mem_wdata, q[0].d);
        shadow[int'(q[0].a)] = q[0].d;
        void'(q.pop_front());
      end else if (clearing) begin
        chk("rnd_cw_we", mem_we, 1);
        chk("rnd_cw_addr", mem_addr, caddr);
        chk("rnd_cw_data", mem_wdata, ccol);
        shadow[caddr] = ccol;
        if (caddr == LAST) clearing = 0;
        else caddr++;
      end else begin
        chk("rnd_idle_en", mem_en, 0);
      end
      if (wr_valid && exp_ready) q.push_back('{wr_addr, wr_data});
      if (clr_start && !clearing_pre) begin
        clearing = 1; caddr = 0; ccol = clr_color;
      end
      prev_req = disp_req;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
